uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single UART byte transmitter (TX + baud generator pair) among N_REQ requesters, e.g. the BIP result reporter and the debug dump unit.
- Grants the transmitter for a whole multi-byte frame, round-robin at frame granularity.
- Issues one tx_start per byte and paces each requester's bytes on tx_done.
- Sits between the requesters and the TX instance; the TX instance is the only consumer of o_tx_start/o_tx_data.

## Interface
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width.
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  N_REQ  bit k high = requester k wants, or holds, the transmitter. It must stay high for the whole frame.
- i_data  in  N_REQ*DATA_W  byte of requester k on bits [k*DATA_W +: DATA_W].
- i_last  in  N_REQ  bit k high = current byte of requester k is the last byte of its frame.
- o_ack  out  N_REQ  one-cycle pulse on bit k when requester k's current byte is handed to TX. The requester presents its next byte and last flag from the following cycle.
- o_grant  out  N_REQ  one-hot owner of the transmitter; all zero when idle.
- o_busy  out  1  high whenever state is not IDLE.
- o_tx_start  out  1  one-cycle start pulse to TX.
- o_tx_data  out  DATA_W  byte to TX; valid while o_tx_start is high.
- i_tx_done  in  1  one-cycle pulse from TX at the end of the stop bit.

## Operation
- Reset values: state IDLE, round-robin pointer 0, o_ack 0, o_grant 0, o_busy 0, o_tx_start 0, o_tx_data 0.
- All outputs are registered.
- States:
  - IDLE: if any i_req bit is high, select the first requester at or after the pointer, searching upward with wrap. Load o_grant and go to LOAD. Otherwise stay.
  - LOAD: if i_req[owner] is low (abort), go to IDLE, clear o_grant and advance the pointer. Otherwise register o_tx_data = owner's byte, o_tx_start = 1, o_ack[owner] = 1, and latch i_last[owner] into last_q. Go to WAIT.
  - WAIT: on i_tx_done:
    - last_q = 1: go to IDLE, clear o_grant, pointer = owner+1 (mod N_REQ).
    - last_q = 0: go to LOAD.
    - Without i_tx_done, stay in WAIT.
- i_tx_done is ignored in IDLE and LOAD.
- i_req changes from non-owners never affect the current frame. They are evaluated only in IDLE.
- A requester dropping i_req during WAIT does not cancel the byte already in flight. The abort is taken at the next LOAD.
- Pointer wrap: owner N_REQ-1 → pointer 0.
- A single-byte frame is a byte with i_last already high at LOAD.
- Reset mid-frame: outputs clear immediately (asynchronous). A TX byte in flight is not tracked after reset; TX is reset by the same rst.

## Timing
- Request i_req[k] rising at edge N, in IDLE:
  - o_grant[k] and LOAD at N+1.
  - o_tx_start, o_ack[k] and o_tx_data valid during the cycle after edge N+2, each for exactly one cycle.
  - State is WAIT from N+2.
- i_tx_done sampled high at edge M in WAIT: LOAD at M+1, next o_tx_start at M+2.
  - Gap between bytes: 2 clk after tx_done.
- Last byte's i_tx_done at edge M: IDLE at M+1. A pending request is granted at M+2.
- o_busy is high from the LOAD entry edge through the IDLE entry edge, exclusive.
- Requester data is sampled only on the LOAD→WAIT edge. It must be stable during LOAD.

## Test plan
- Single frame: N_REQ=2, requester 0 sends 0x12, 0x34, 0x56 (last on 0x56), with tx_done 10 cycles after each start.
  - Expect exactly 3 tx_start pulses carrying 0x12, 0x34, 0x56.
  - Expect 3 ack[0] pulses coincident with the starts.
  - Expect IDLE and pointer = 1 afterwards.
- Simultaneous requests after reset: requester 0 frame {0xA0, 0xA1}, requester 1 frame {0xB0}.
  - Expect TX order 0xA0, 0xA1, 0xB0.
  - Expect grant 01 → 10 → 00.
- Fairness: both requesters hold i_req continuously with 1-byte frames (0xAA / 0xBB).
  - Expect alternating 0xAA, 0xBB, 0xAA, 0xBB over 4 frames.
- Abort: requester 1 drops i_req after its first byte 0xC0 while requester 0 is requesting.
  - Expect no second tx_start for requester 1 and IDLE at the LOAD edge.
  - Expect requester 0 granted 1 cycle later with pointer = 0.
- Spurious done and reset:
  - A tx_done pulse in IDLE produces no tx_start.
  - Asserting rst low in WAIT mid-frame clears grant, busy, tx_start and ack within the same cycle.
  - After release, the next request restarts at pointer 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-side signals of the shared UART transmitter arbiter.
// The arbiter uses the slave modport; requesters and the TX model use master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        last;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done;

  modport master (output req, data, last, tx_done,
                  input  ack, grant, busy, tx_start, tx_data);
  modport slave  (input  req, data, last, tx_done,
                  output ack, grant, busy, tx_start, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of a single UART byte transmitter.
// One tx_start per byte; the next byte of the owning frame is loaded after tx_done.
module uart_tx_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n, owner, owner_n, owner_inc, sel;
  logic [N_REQ-1:0]  grant, grant_n, ack, ack_n;
  logic              start, start_n, last_q, last_n, busy, found;
  logic [DATA_W-1:0] txd, txd_n;
  logic [PW:0]       sum;

  // First requesting index at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      if (!found && bus.req[sum[PW-1:0]]) begin
        found = 1'b1;
        sel   = sum[PW-1:0];
      end
    end
  end

  assign owner_inc = (owner == PW'(N_REQ-1)) ? '0 : owner + PW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    grant_n = grant;
    ack_n   = '0;
    start_n = 1'b0;
    txd_n   = txd;
    last_n  = last_q;
    case (state)
      IDLE: if (found) begin
        owner_n      = sel;
        grant_n      = '0;
        grant_n[sel] = 1'b1;
        state_n      = LOAD;
      end
      LOAD: if (!bus.req[owner]) begin
        // owner withdrew between bytes: give up the frame and move on
        grant_n = '0;
        ptr_n   = owner_inc;
        state_n = IDLE;
      end else begin
        txd_n        = bus.data[int'(owner)*DATA_W +: DATA_W];
        start_n      = 1'b1;
        ack_n[owner] = 1'b1;
        last_n       = bus.last[owner];
        state_n      = WAIT;
      end
      WAIT: if (bus.tx_done) begin
        if (last_q) begin
          grant_n = '0;
          ptr_n   = owner_inc;
          state_n = IDLE;
        end else begin
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      grant  <= '0;
      ack    <= '0;
      start  <= 1'b0;
      txd    <= '0;
      last_q <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      grant  <= grant_n;
      ack    <= ack_n;
      start  <= start_n;
      txd    <= txd_n;
      last_q <= last_n;
      busy   <= (state_n != IDLE);
    end
  end

  assign bus.ack      = ack;
  assign bus.grant    = grant;
  assign bus.busy     = busy;
  assign bus.tx_start = start;
  assign bus.tx_data  = txd;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed frames, a TX model answering
// tx_done 10 cycles after each start, and a monitor checking every tx_start.
module tb_uart_tx_arbiter;
  localparam int N = 2;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int own; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   start_cyc[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, start_cnt = 0;

  logic [7:0] fd [N][32];
  logic       fl [N][32];
  int         qn [N] = '{0, 0};
  int         qh [N] = '{0, 0};
  logic       drop [N] = '{1'b0, 1'b0};
  logic       mdl_done, spur_done = 1'b0;
  int         tx_cnt;

  assign bus.tx_done = mdl_done | spur_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // TX stand-in: one tx_done pulse per start, 10 cycles later
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt   <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (bus.tx_start) tx_cnt <= 10;
      else if (tx_cnt == 1) begin
        tx_cnt   <= 0;
        mdl_done <= 1'b1;
      end else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
  end

  // Requesters: present queue head, pop on ack, optionally withdraw after an ack
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (rst && bus.ack[k] && qh[k] < qn[k]) qh[k] = drop[k] ? qn[k] : qh[k] + 1;
      bus.req[k]          = (qh[k] < qn[k]);
      bus.data[k*W +: W]  = (qh[k] < qn[k]) ? fd[k][qh[k]] : 8'h00;
      bus.last[k]         = (qh[k] < qn[k]) ? fl[k][qh[k]] : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (bus.tx_start) begin
        start_cnt++;
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: data %0h with nothing expected", bus.tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_data", {24'h0, bus.tx_data}, {24'h0, mon_e.d});
          chk("ack", {30'h0, bus.ack}, 32'(1 << mon_e.own));
          chk("grant", {30'h0, bus.grant}, 32'(1 << mon_e.own));
        end
      end else if (bus.ack != '0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ack_without_start: ack %0h", bus.ack);
      end
    end
  end

  task automatic push(input int k, input logic [7:0] b, input logic l);
    fd[k][qn[k]] = b;
    fl[k][qn[k]] = l;
    qn[k]++;
  endtask

  task automatic expect_tx(input int k, input logic [7:0] b);
    exp_q.push_back('{own: k, d: b});
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while ((exp_q.size() != 0 || bus.busy || qh[0] < qn[0] || qh[1] < qn[1]) && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (c >= 400) timeout(nm);
    chk({nm, "_grant_idle"}, {30'h0, bus.grant}, 32'h0);
    chk({nm, "_busy_idle"}, {31'h0, bus.busy}, 32'h0);
  endtask

  task automatic wait_start(input int s, input string nm);
    int c = 0;
    while (start_cnt <= s && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) timeout(nm);
  endtask

  initial begin
    int s, c;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'h0, bus.grant}, 32'h0);
    chk("rst_ack", {30'h0, bus.ack}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // single 3-byte frame, with latency and byte pacing
    s = start_cnt;
    push(0, 8'h12, 0); push(0, 8'h34, 0); push(0, 8'h56, 1);
    expect_tx(0, 8'h12); expect_tx(0, 8'h34); expect_tx(0, 8'h56);
    @(negedge clk);
    chk("t1_grant_early", {30'h0, bus.grant}, 32'h0);
    @(negedge clk);
    chk("t1_grant_load", {30'h0, bus.grant}, 32'h1);
    chk("t1_busy_load", {31'h0, bus.busy}, 32'h1);
    chk("t1_start_load", {31'h0, bus.tx_start}, 32'h0);
    @(negedge clk);
    chk("t1_start_first", {31'h0, bus.tx_start}, 32'h1);
    wait_done("t1");
    chk("t1_starts", 32'(start_cnt - s), 32'd3);
    if (start_cyc.size() >= s + 3) begin
      chk("t1_gap01", 32'(start_cyc[s+1] - start_cyc[s]), 32'd13);
      chk("t1_gap12", 32'(start_cyc[s+2] - start_cyc[s+1]), 32'd13);
    end else timeout("t1_gaps");

    // pointer sits at 1: requester 1 wins a tie
    push(0, 8'hE0, 1); push(1, 8'hE1, 1);
    expect_tx(1, 8'hE1); expect_tx(0, 8'hE0);
    wait_done("t1_ptr");

    // simultaneous requests from reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(0, 8'hA0, 0); push(0, 8'hA1, 1); push(1, 8'hB0, 1);
    expect_tx(0, 8'hA0); expect_tx(0, 8'hA1); expect_tx(1, 8'hB0);
    wait_done("t2");

    // fairness with continuous single-byte frames
    push(0, 8'hAA, 1); push(0, 8'hAA, 1); push(1, 8'hBB, 1); push(1, 8'hBB, 1);
    expect_tx(0, 8'hAA); expect_tx(1, 8'hBB); expect_tx(0, 8'hAA); expect_tx(1, 8'hBB);
    wait_done("t3");

    // abort: requester 1 withdraws after its first byte
    drop[1] = 1'b1;
    s = start_cnt;
    push(1, 8'hC0, 0); push(1, 8'hC1, 1);
    expect_tx(1, 8'hC0);
    wait_start(s, "t4_start");
    push(0, 8'hD0, 1);
    expect_tx(0, 8'hD0);
    c = 0;
    while (bus.busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) timeout("t4_abort_idle");
    chk("t4_abort_grant", {30'h0, bus.grant}, 32'h0);
    @(negedge clk);
    chk("t4_regrant", {30'h0, bus.grant}, 32'h1);
    chk("t4_regrant_busy", {31'h0, bus.busy}, 32'h1);
    wait_done("t4");
    drop[1] = 1'b0;

    // stray tx_done while idle
    s = start_cnt;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_spur_starts", 32'(start_cnt - s), 32'd0);
    chk("t5_spur_busy", {31'h0, bus.busy}, 32'h0);

    // reset in the middle of a frame
    s = start_cnt;
    push(1, 8'hF0, 0); push(1, 8'hF1, 1);
    expect_tx(1, 8'hF0);
    wait_start(s, "t5_start");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rst_grant", {30'h0, bus.grant}, 32'h0);
    chk("t5_rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("t5_rst_start", {31'h0, bus.tx_start}, 32'h0);
    chk("t5_rst_ack", {30'h0, bus.ack}, 32'h0);
    for (int k = 0; k < N; k++) qn[k] = qh[k];
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(0, 8'h60, 1); push(1, 8'h61, 1);
    expect_tx(0, 8'h60); expect_tx(1, 8'h61);
    wait_done("t5_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
